load_buffer: RTL

//  Parametrised load buffer between load RS and D-cache/CDB. Replaces the fixed one-entry-per-FU load queue.
//  - DEPTH shared entries; any of NUM_PORTS issue ports may allocate into any free entry.
//  - Flow: AG stage (address add), then SQ stage (store-queue forward query), then buffer entry.
//  - From the entry: D-cache request arbitration, then CDB broadcast of aligned, sign-extended data.
//  - Full-pipeline squash, with epoch-tagged D-cache responses so late responses are dropped.

---
 rtl/load_buffer.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_buffer.sv
// Shared load buffer: AG and SQ-query stages per issue port feed DEPTH entries that
// arbitrate for D-cache channels and broadcast aligned, extended results on the CDB.
module load_buffer #(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 8,
  parameter int NUM_DC    = 2,
  parameter int NUM_RESP  = 2,
  parameter int NUM_CDB   = 2,
  parameter int PRN_W     = 6,
  parameter int ROBN_W    = 5,
  parameter int SQ_W      = 3,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int TAG_W    = IDX_W + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic [NUM_PORTS-1:0]        rs_valid,
  input  logic [NUM_PORTS*32-1:0]     rs_base,
  input  logic [NUM_PORTS*12-1:0]     rs_offset,
  input  logic [NUM_PORTS*3-1:0]      rs_func,
  input  logic [NUM_PORTS*PRN_W-1:0]  rs_prn,
  input  logic [NUM_PORTS*ROBN_W-1:0] rs_robn,
  input  logic [NUM_PORTS*SQ_W-1:0]   rs_tail_store,
  output logic [NUM_PORTS-1:0]        rs_ready,
  output logic [NUM_PORTS*32-1:0]     sq_addr,
  output logic [NUM_PORTS*3-1:0]      sq_func,
  output logic [NUM_PORTS*SQ_W-1:0]   sq_range,
  input  logic [NUM_PORTS-1:0]        sq_fwd_valid,
  input  logic [NUM_PORTS*32-1:0]     sq_fwd_data,
  output logic [NUM_DC-1:0]           dc_req_valid,
  output logic [NUM_DC*32-1:0]        dc_req_addr,
  output logic [NUM_DC*3-1:0]         dc_req_func,
  output logic [NUM_DC*TAG_W-1:0]     dc_req_tag,
  input  logic [NUM_DC-1:0]           dc_req_accept,
  input  logic [NUM_DC-1:0]           dc_hit,
  input  logic [NUM_DC*32-1:0]        dc_hit_data,
  input  logic [NUM_RESP-1:0]         dc_resp_valid,
  input  logic [NUM_RESP*TAG_W-1:0]   dc_resp_tag,
  input  logic [NUM_RESP*32-1:0]      dc_resp_data,
  output logic [NUM_CDB-1:0]          cdb_prepared,
  input  logic [NUM_CDB-1:0]          cdb_selected,
  output logic [NUM_CDB*PRN_W-1:0]    cdb_prn,
  output logic [NUM_CDB*ROBN_W-1:0]   cdb_robn,
  output logic [NUM_CDB*32-1:0]       cdb_result
);

  typedef enum logic [1:0] {FREE, NOFWD, ASKED, KNOWN} state_t;

  function automatic logic [31:0] align_result(input logic [31:0] word,
                                               input logic [1:0]  ofs,
                                               input logic [2:0]  func);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {ofs, 3'b000};
    case (func[1:0])
      2'd0:    res = func[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    res = func[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Entry storage: state/epoch are control, the rest is datapath
  state_t            st     [DEPTH];
  logic              ep     [DEPTH];
  logic [31:0]       e_addr [DEPTH];
  logic [2:0]        e_func [DEPTH];
  logic [PRN_W-1:0]  e_prn  [DEPTH];
  logic [ROBN_W-1:0] e_robn [DEPTH];
  logic [31:0]       e_word [DEPTH];
  logic              epoch;

  logic [NUM_PORTS-1:0] vld_p1, vld_p2, fwd_p2;
  logic [31:0]          addr_p1 [NUM_PORTS];
  logic [31:0]          addr_p2 [NUM_PORTS];
  logic [2:0]           func_p1 [NUM_PORTS];
  logic [2:0]           func_p2 [NUM_PORTS];
  logic [PRN_W-1:0]     prn_p1  [NUM_PORTS];
  logic [PRN_W-1:0]     prn_p2  [NUM_PORTS];
  logic [ROBN_W-1:0]    robn_p1 [NUM_PORTS];
  logic [ROBN_W-1:0]    robn_p2 [NUM_PORTS];
  logic [SQ_W-1:0]      tail_p1 [NUM_PORTS];
  logic [31:0]          fdata_p2[NUM_PORTS];

  // p0: address generation from issue inputs
  logic signed [11:0] off_p0     [NUM_PORTS];
  logic signed [31:0] off_ext_p0 [NUM_PORTS];
  logic [31:0]        ag_addr_p0 [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      off_p0[p]     = signed'(rs_offset[p*12 +: 12]);
      off_ext_p0[p] = 32'(off_p0[p]);
      ag_addr_p0[p] = rs_base[p*32 +: 32] + unsigned'(off_ext_p0[p]);
    end
  end

  // Free entries not yet claimed by loads in flight through AG/SQ
  int free_cnt, avail;
  always_comb begin
    free_cnt = 0;
    for (int i = 0; i < DEPTH; i++)
      if (st[i] == FREE) free_cnt++;
    avail = free_cnt - $countones(vld_p1) - $countones(vld_p2);
    for (int p = 0; p < NUM_PORTS; p++)
      rs_ready[p] = (avail > p);
  end

  logic [NUM_PORTS-1:0] alloc_ok;
  logic [IDX_W-1:0]     alloc_idx [NUM_PORTS];
  logic [DEPTH-1:0]     alloc_taken;
  always_comb begin
    alloc_taken = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      alloc_ok[p]  = 1'b0;
      alloc_idx[p] = '0;
      if (vld_p2[p]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!alloc_ok[p] && st[i] == FREE && !alloc_taken[i]) begin
            alloc_ok[p]    = 1'b1;
            alloc_idx[p]   = IDX_W'(i);
            alloc_taken[i] = 1'b1;
          end
        end
      end
    end
  end

  logic [NUM_DC-1:0] dc_vld;
  logic [IDX_W-1:0]  dc_idx [NUM_DC];
  logic [DEPTH-1:0]  dc_taken;
  always_comb begin
    dc_taken = '0;
    for (int c = 0; c < NUM_DC; c++) begin
      dc_vld[c] = 1'b0;
      dc_idx[c] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!dc_vld[c] && st[i] == NOFWD && !dc_taken[i]) begin
          dc_vld[c]   = 1'b1;
          dc_idx[c]   = IDX_W'(i);
          dc_taken[i] = 1'b1;
        end
      end
    end
  end

  logic [NUM_CDB-1:0] cdb_vld;
  logic [IDX_W-1:0]   cdb_idx [NUM_CDB];
  logic [DEPTH-1:0]   cdb_taken;
  always_comb begin
    cdb_taken = '0;
    for (int s = 0; s < NUM_CDB; s++) begin
      cdb_vld[s] = 1'b0;
      cdb_idx[s] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!cdb_vld[s] && st[i] == KNOWN && !cdb_taken[i]) begin
          cdb_vld[s]   = 1'b1;
          cdb_idx[s]   = IDX_W'(i);
          cdb_taken[i] = 1'b1;
        end
      end
    end
  end

  // A fill only lands on an ASKED entry whose recorded epoch matches the tag
  logic [NUM_RESP-1:0] resp_hit;
  logic [IDX_W-1:0]    resp_idx [NUM_RESP];
  always_comb begin
    for (int r = 0; r < NUM_RESP; r++) begin
      resp_idx[r] = dc_resp_tag[r*TAG_W +: IDX_W];
      resp_hit[r] = dc_resp_valid[r] && st[resp_idx[r]] == ASKED &&
                    ep[resp_idx[r]] == dc_resp_tag[r*TAG_W + IDX_W];
    end
  end

  always_comb begin
    sq_addr  = '0;
    sq_func  = '0;
    sq_range = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sq_addr[p*32 +: 32]    = vld_p1[p] ? addr_p1[p] : 32'd0;
      sq_func[p*3 +: 3]      = vld_p1[p] ? func_p1[p] : 3'd0;
      sq_range[p*SQ_W +: SQ_W] = vld_p1[p] ? tail_p1[p] : '0;
    end
  end

  always_comb begin
    dc_req_valid = dc_vld;
    dc_req_addr  = '0;
    dc_req_func  = '0;
    dc_req_tag   = '0;
    for (int c = 0; c < NUM_DC; c++) begin
      if (dc_vld[c]) begin
        dc_req_addr[c*32 +: 32]      = e_addr[dc_idx[c]];
        dc_req_func[c*3 +: 3]        = e_func[dc_idx[c]];
        dc_req_tag[c*TAG_W +: TAG_W] = {epoch, dc_idx[c]};
      end
    end
  end

  always_comb begin
    cdb_prepared = cdb_vld;
    cdb_prn      = '0;
    cdb_robn     = '0;
    cdb_result   = '0;
    for (int s = 0; s < NUM_CDB; s++) begin
      if (cdb_vld[s]) begin
        cdb_prn[s*PRN_W +: PRN_W]    = e_prn[cdb_idx[s]];
        cdb_robn[s*ROBN_W +: ROBN_W] = e_robn[cdb_idx[s]];
        cdb_result[s*32 +: 32]       = align_result(e_word[cdb_idx[s]],
                                                    e_addr[cdb_idx[s]][1:0],
                                                    e_func[cdb_idx[s]]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= '0;
      vld_p2 <= '0;
      epoch  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        st[i] <= FREE;
        ep[i] <= 1'b0;
      end
    end else if (squash) begin
      vld_p1 <= '0;
      vld_p2 <= '0;
      epoch  <= ~epoch;
      for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
    end else begin
      vld_p1 <= rs_valid & rs_ready;
      vld_p2 <= vld_p1;
      for (int c = 0; c < NUM_DC; c++) begin
        if (dc_vld[c] && dc_req_accept[c]) begin
          st[dc_idx[c]] <= dc_hit[c] ? KNOWN : ASKED;
          ep[dc_idx[c]] <= epoch;
        end
      end
      for (int r = 0; r < NUM_RESP; r++)
        if (resp_hit[r]) st[resp_idx[r]] <= KNOWN;
      for (int s = 0; s < NUM_CDB; s++)
        if (cdb_vld[s] && cdb_selected[s]) st[cdb_idx[s]] <= FREE;
      for (int p = 0; p < NUM_PORTS; p++)
        if (alloc_ok[p]) st[alloc_idx[p]] <= fwd_p2[p] ? KNOWN : NOFWD;
    end
  end

  // p1: AG register, p2: SQ register, then entry write
  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_p1[p]  <= ag_addr_p0[p];
      func_p1[p]  <= rs_func[p*3 +: 3];
      prn_p1[p]   <= rs_prn[p*PRN_W +: PRN_W];
      robn_p1[p]  <= rs_robn[p*ROBN_W +: ROBN_W];
      tail_p1[p]  <= rs_tail_store[p*SQ_W +: SQ_W];
      addr_p2[p]  <= addr_p1[p];
      func_p2[p]  <= func_p1[p];
      prn_p2[p]   <= prn_p1[p];
      robn_p2[p]  <= robn_p1[p];
      fwd_p2[p]   <= sq_fwd_valid[p];
      fdata_p2[p] <= sq_fwd_data[p*32 +: 32];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (alloc_ok[p]) begin
        e_addr[alloc_idx[p]] <= addr_p2[p];
        e_func[alloc_idx[p]] <= func_p2[p];
        e_prn[alloc_idx[p]]  <= prn_p2[p];
        e_robn[alloc_idx[p]] <= robn_p2[p];
        e_word[alloc_idx[p]] <= fdata_p2[p];
      end
    end
    for (int c = 0; c < NUM_DC; c++)
      if (dc_vld[c] && dc_req_accept[c] && dc_hit[c])
        e_word[dc_idx[c]] <= dc_hit_data[c*32 +: 32];
    for (int r = 0; r < NUM_RESP; r++)
      if (resp_hit[r]) e_word[resp_idx[r]] <= dc_resp_data[r*32 +: 32];
  end

endmodule
